// File: rtl/apb_ram_pkg.sv
// Shared types and constants for the APB4 wait-state RAM slave and its storage array.
package apb_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int MAX_WAIT_STATES = 15;
    localparam int CNT_W           = 4;

    // Byte-offset bits within one data word (0 for an 8-bit bus).
    function automatic int lsb_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int idx_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_ram_mem.sv
// Word-organised RAM: synchronous write with per-byte enables, combinational read.
module apb_ram_mem
    import apb_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int IDX_W      = 6
) (
    input  logic                    PCLK,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [IDX_W-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge PCLK) begin
        for (int b = 0; b < NB; b++) begin
            if (we[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Guard against indices past DEPTH when DEPTH is not a power of two.
    assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/apb4_ram_ws.sv
// APB4 slave RAM with byte strobes, programmable wait states and error response.
// Optional write protection of the lowest RO_WORDS words: define APB_RAM_WRITE_PROTECT_EN.
module apb4_ram_ws
    import apb_ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1,
    parameter int RO_WORDS    = 4
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int LSB   = lsb_bits(DATA_WIDTH);
    localparam int IDX_W = idx_bits(DEPTH);
    localparam int WS    = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;

    localparam logic [CNT_W-1:0]      WS_CNT     = CNT_W'(WS);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   RO_LIM     = (ADDR_WIDTH + 1)'(RO_WORDS);

`ifdef APB_RAM_WRITE_PROTECT_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [IDX_W-1:0]      lat_idx, lat_idx_n;
    logic                  lat_write, lat_write_n;
    logic                  lat_err, lat_err_n;
    logic [DATA_WIDTH-1:0] prdata_n;
    logic                  pready_n;
    logic                  pslverr_n;

    logic [ADDR_WIDTH-1:0] cur_idx;
    logic                  cur_err;
    logic [IDX_W-1:0]      mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [NB-1:0]         mem_we;

    // Decode of the address currently on the bus; only meaningful in the setup phase.
    assign cur_idx = PADDR >> LSB;
    assign cur_err = (|(PADDR & ALIGN_MASK))
                   | ({1'b0, cur_idx} >= DEPTH_LIM)
                   | (WP_EN & PWRITE & ({1'b0, cur_idx} < RO_LIM));

    // With zero wait states the read completes straight out of setup, before idx is latched.
    assign mem_raddr = (state == IDLE) ? cur_idx[IDX_W-1:0] : lat_idx;

    apb_ram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .PCLK  (PCLK),
        .we    (mem_we),
        .waddr (lat_idx),
        .wdata (PWDATA),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            PRDATA    <= '0;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            lat_idx   <= lat_idx_n;
            lat_write <= lat_write_n;
            lat_err   <= lat_err_n;
            PRDATA    <= prdata_n;
            PREADY    <= pready_n;
            PSLVERR   <= pslverr_n;
        end
    end

    // PREADY/PSLVERR default low so every exit from RESP (or a dropped PSEL) clears them.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        lat_idx_n   = lat_idx;
        lat_write_n = lat_write;
        lat_err_n   = lat_err;
        prdata_n    = PRDATA;
        pready_n    = 1'b0;
        pslverr_n   = 1'b0;
        mem_we      = '0;

        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    lat_idx_n   = cur_idx[IDX_W-1:0];
                    lat_write_n = PWRITE;
                    lat_err_n   = cur_err;
                    cnt_n       = WS_CNT;
                    if (WS == 0) begin
                        state_n   = RESP;
                        pready_n  = 1'b1;
                        pslverr_n = cur_err;
                        if (!PWRITE) begin
                            prdata_n = cur_err ? '0 : mem_rdata;
                        end
                    end else begin
                        state_n = WAIT;
                    end
                end
            end

            WAIT: begin
                if (!PSEL) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                    if (cnt <= CNT_ONE) begin
                        state_n   = RESP;
                        pready_n  = 1'b1;
                        pslverr_n = lat_err;
                        if (!lat_write) begin
                            prdata_n = lat_err ? '0 : mem_rdata;
                        end
                    end
                end
            end

            RESP: begin
                state_n = IDLE;
                if (PSEL && PENABLE && lat_write && !lat_err) begin
                    mem_we = PSTRB;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb4_ram_ws.sv
// Self-checking bench for apb4_ram_ws: three instances (WS=1/AW=9, WS=0, WS=3) against a word-array model.
module tb_apb4_ram_ws;

`ifdef APB_RAM_WRITE_PROTECT_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [2:0]  psel;
    logic        PENABLE;
    logic        PWRITE;
    logic [8:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] prd [3];
    logic        rdy [3];
    logic        slv [3];

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mdl [3][64];
    bit          known [3][64];
    logic [31:0] last_rd [3];
    bit          last_known [3];

    always #5 PCLK = ~PCLK;

    apb4_ram_ws #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(1), .RO_WORDS(4)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(prd[0]), .PREADY(rdy[0]), .PSLVERR(slv[0]));

    apb4_ram_ws #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0), .RO_WORDS(4)) dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR[7:0]), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(prd[1]), .PREADY(rdy[1]), .PSLVERR(slv[1]));

    apb4_ram_ws #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3), .RO_WORDS(4)) dut2 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR[7:0]), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(prd[2]), .PREADY(rdy[2]), .PSLVERR(slv[2]));

    function automatic int ws_of(input int s);
        case (s)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic bit m_err(input logic [8:0] a, input bit wr);
        int idx;
        idx = int'(a) / 4;
        if ((int'(a) % 4) != 0) return 1'b1;
        if (idx >= 64) return 1'b1;
        if (WP_ON && wr && idx < 4) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: predicted PSLVERR and PRDATA for one transfer, then commit its effect.
    task automatic m_predict(input int s, input bit wr, input logic [8:0] a, input logic [31:0] wd,
                             input logic [3:0] st, output logic [31:0] erd, output bit eerr,
                             output bit dknown);
        int idx;
        idx  = int'(a) / 4;
        eerr = m_err(a, wr);
        if (wr) begin
            erd    = last_rd[s];
            dknown = last_known[s];
            if (!eerr) begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) mdl[s][idx][8*b +: 8] = wd[8*b +: 8];
                if (st == 4'hF) known[s][idx] = 1'b1;
            end
        end else if (eerr) begin
            erd    = 32'h0;
            dknown = 1'b1;
        end else begin
            erd    = mdl[s][idx];
            dknown = known[s][idx];
        end
        if (!wr) begin
            last_rd[s]    = erd;
            last_known[s] = dknown;
        end
    endtask

    task automatic applyStimulus(input int s, input bit wr, input logic [8:0] a, input logic [31:0] wd,
                                 input logic [3:0] st, input bit glitch, output logic [31:0] rd,
                                 output bit er, output int low, output bit tmo);
        PADDR   = a;
        PWRITE  = wr;
        PWDATA  = wd;
        PSTRB   = st;
        PENABLE = 1'b0;
        psel    = 3'b000;
        psel[s] = 1'b1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        if (glitch) PADDR = 9'($urandom);
        low = 0;
        tmo = 1'b0;
        while (rdy[s] !== 1'b1) begin
            if (low >= 40) begin
                tmo = 1'b1;
                break;
            end
            low++;
            @(posedge PCLK); #1;
        end
        rd = prd[s];
        er = slv[s];
        @(posedge PCLK); #1;
        psel    = 3'b000;
        PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        PRESET  = 1'b1;
        psel    = 3'b000;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        PSTRB   = '0;
        repeat (2) @(posedge PCLK);
        #1;
        for (int s = 0; s < 3; s++) begin
            compared++;
            if (prd[s] !== 32'h0 || rdy[s] !== 1'b0 || slv[s] !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_outputs dut%0d: got prdata=%h pready=%b pslverr=%b, need 0/0/0",
                         s, prd[s], rdy[s], slv[s]);
            end
            last_rd[s]    = 32'h0;
            last_known[s] = 1'b1;
        end
        PRESET = 1'b0;
        @(posedge PCLK); #1;
    endtask

    task automatic test_init();
        logic [31:0] rd, erd, wd;
        bit er, eerr, dk, tmo;
        int low;
        for (int s = 0; s < 3; s++) begin
            for (int w = 0; w < 64; w++) begin
                wd = (s == 0 && w == 8) ? 32'h0 : $urandom;
                applyStimulus(s, 1'b1, 9'(w * 4), wd, 4'hF, 1'b0, rd, er, low, tmo);
                m_predict(s, 1'b1, 9'(w * 4), wd, 4'hF, erd, eerr, dk);
                compared++;
                if (tmo || er !== eerr || low != ws_of(s)) begin
                    mismatched++;
                    $display("[TB] FAIL init_write dut%0d w%0d: got err=%b low=%0d tmo=%b, need err=%b low=%0d",
                             s, w, er, low, tmo, eerr, ws_of(s));
                end
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd, erd;
        bit er, eerr, dk, tmo;
        int low;
        applyStimulus(0, 1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 1'b0, rd, er, low, tmo);
        m_predict(0, 1'b1, 9'h010, 32'hDEADBEEF, 4'hF, erd, eerr, dk);
        compared++;
        if (tmo || low != 1 || er !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_write: got low=%0d err=%b tmo=%b, need low=1 err=0", low, er, tmo);
        end
        applyStimulus(0, 1'b0, 9'h010, 32'h0, 4'h0, 1'b0, rd, er, low, tmo);
        m_predict(0, 1'b0, 9'h010, 32'h0, 4'h0, erd, eerr, dk);
        compared++;
        if (tmo || low != 1 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            mismatched++;
            $display("[TB] FAIL basic_read: got data=%h low=%0d err=%b, need data=deadbeef low=1 err=0",
                     rd, low, er);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] rd, erd;
        bit er, eerr, dk, tmo;
        int low;
        applyStimulus(0, 1'b1, 9'h014, 32'h11223344, 4'hF, 1'b0, rd, er, low, tmo);
        m_predict(0, 1'b1, 9'h014, 32'h11223344, 4'hF, erd, eerr, dk);
        applyStimulus(0, 1'b1, 9'h014, 32'hAABBCCDD, 4'h5, 1'b0, rd, er, low, tmo);
        m_predict(0, 1'b1, 9'h014, 32'hAABBCCDD, 4'h5, erd, eerr, dk);
        compared++;
        if (tmo || er !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL strobe_write: got err=%b tmo=%b, need err=0", er, tmo);
        end
        applyStimulus(0, 1'b0, 9'h014, 32'h0, 4'h0, 1'b0, rd, er, low, tmo);
        m_predict(0, 1'b0, 9'h014, 32'h0, 4'h0, erd, eerr, dk);
        compared++;
        if (rd !== 32'h11BB33DD || er !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL strobe_read: got data=%h err=%b, need 11bb33dd err=0", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd;
        bit er, eerr, dk, tmo;
        int low;
        applyStimulus(0, 1'b0, 9'h012, 32'h0, 4'hF, 1'b0, rd, er, low, tmo);
        m_predict(0, 1'b0, 9'h012, 32'h0, 4'hF, erd, eerr, dk);
        compared++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL misaligned_read: got err=%b data=%h, need err=1 data=0", er, rd);
        end
        applyStimulus(0, 1'b1, 9'h100, 32'h55AA55AA, 4'hF, 1'b0, rd, er, low, tmo);
        m_predict(0, 1'b1, 9'h100, 32'h55AA55AA, 4'hF, erd, eerr, dk);
        compared++;
        if (er !== 1'b1 || tmo) begin
            mismatched++;
            $display("[TB] FAIL oob_write: got err=%b tmo=%b, need err=1", er, tmo);
        end
        applyStimulus(0, 1'b0, 9'h000, 32'h0, 4'h0, 1'b0, rd, er, low, tmo);
        m_predict(0, 1'b0, 9'h000, 32'h0, 4'h0, erd, eerr, dk);
        compared++;
        if (er !== 1'b0 || (dk && rd !== erd) || rd === 32'h55AA55AA) begin
            mismatched++;
            $display("[TB] FAIL oob_no_alias: got data=%h err=%b, need data=%h err=0", rd, er, erd);
        end
    endtask

    task automatic test_wait_sweep();
        logic [31:0] rd, erd, wd;
        bit er, eerr, dk, tmo;
        int low;
        wd = $urandom;
        applyStimulus(1, 1'b1, 9'h040, wd, 4'hF, 1'b0, rd, er, low, tmo);
        m_predict(1, 1'b1, 9'h040, wd, 4'hF, erd, eerr, dk);
        applyStimulus(1, 1'b0, 9'h040, 32'h0, 4'h0, 1'b0, rd, er, low, tmo);
        m_predict(1, 1'b0, 9'h040, 32'h0, 4'h0, erd, eerr, dk);
        compared++;
        if (tmo || low != 0 || rd !== wd) begin
            mismatched++;
            $display("[TB] FAIL ws0_read: got data=%h low=%0d, need data=%h low=0", rd, low, wd);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2, 1'b0, 9'(64 + 4 * i), 32'h0, 4'h0, 1'b0, rd, er, low, tmo);
            m_predict(2, 1'b0, 9'(64 + 4 * i), 32'h0, 4'h0, erd, eerr, dk);
            compared++;
            if (tmo || low != 3 || rd !== erd || er !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL ws3_read%0d: got data=%h low=%0d err=%b, need data=%h low=3 err=0",
                         i, rd, low, er, erd);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd;
        bit er, eerr, dk, tmo;
        int low;
        applyStimulus(0, 1'b0, 9'h010, 32'h0, 4'h0, 1'b0, rd, er, low, tmo);
        m_predict(0, 1'b0, 9'h010, 32'h0, 4'h0, erd, eerr, dk);
        PADDR   = 9'h020;
        PWRITE  = 1'b1;
        PWDATA  = 32'hCAFEF00D;
        PSTRB   = 4'hF;
        psel[0] = 1'b1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PRESET  = 1'b1;
        #1;
        compared++;
        if (prd[0] !== 32'h0 || rdy[0] !== 1'b0 || slv[0] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid: got prdata=%h pready=%b pslverr=%b, need 0/0/0",
                     prd[0], rdy[0], slv[0]);
        end
        repeat (2) @(posedge PCLK);
        #1;
        psel    = 3'b000;
        PENABLE = 1'b0;
        PRESET  = 1'b0;
        for (int s = 0; s < 3; s++) begin
            last_rd[s]    = 32'h0;
            last_known[s] = 1'b1;
        end
        @(posedge PCLK); #1;
        applyStimulus(0, 1'b0, 9'h020, 32'h0, 4'h0, 1'b0, rd, er, low, tmo);
        m_predict(0, 1'b0, 9'h020, 32'h0, 4'h0, erd, eerr, dk);
        compared++;
        if (tmo || rd !== 32'h0 || er !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_drops_write: got data=%h err=%b, need 00000000 err=0", rd, er);
        end
    endtask

    task automatic test_psel_drop();
        logic [31:0] rd, erd;
        bit er, eerr, dk, tmo;
        int low;
        PADDR   = 9'h014;
        PWRITE  = 1'b1;
        PWDATA  = 32'hFFFFFFFF;
        PSTRB   = 4'hF;
        psel[0] = 1'b1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        psel    = 3'b000;
        @(posedge PCLK); #1;
        compared++;
        if (rdy[0] !== 1'b0 || slv[0] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL psel_drop_ready: got pready=%b pslverr=%b, need 0/0", rdy[0], slv[0]);
        end
        PENABLE = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        applyStimulus(0, 1'b0, 9'h014, 32'h0, 4'h0, 1'b0, rd, er, low, tmo);
        m_predict(0, 1'b0, 9'h014, 32'h0, 4'h0, erd, eerr, dk);
        compared++;
        if (tmo || rd !== 32'h11BB33DD) begin
            mismatched++;
            $display("[TB] FAIL psel_drop_nowrite: got data=%h, need 11bb33dd", rd);
        end
    endtask

    task automatic test_protect();
        logic [31:0] rd, erd;
        bit er, eerr, dk, tmo;
        int low;
        applyStimulus(0, 1'b1, 9'h008, 32'h12345678, 4'hF, 1'b0, rd, er, low, tmo);
        m_predict(0, 1'b1, 9'h008, 32'h12345678, 4'hF, erd, eerr, dk);
        compared++;
        if (tmo || er !== eerr) begin
            mismatched++;
            $display("[TB] FAIL protect_write_err: got err=%b, need %b", er, eerr);
        end
        applyStimulus(0, 1'b0, 9'h008, 32'h0, 4'h0, 1'b0, rd, er, low, tmo);
        m_predict(0, 1'b0, 9'h008, 32'h0, 4'h0, erd, eerr, dk);
        compared++;
        if (dk ? (rd !== erd) : (rd === 32'h12345678)) begin
            mismatched++;
            $display("[TB] FAIL protect_read: got data=%h, need %h (known=%b)", rd, erd, dk);
        end
        applyStimulus(0, 1'b1, 9'h010, 32'h0BADC0DE, 4'hF, 1'b0, rd, er, low, tmo);
        m_predict(0, 1'b1, 9'h010, 32'h0BADC0DE, 4'hF, erd, eerr, dk);
        compared++;
        if (tmo || er !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL unprotected_write: got err=%b, need 0", er);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, erd, wd;
        logic [8:0] a;
        logic [3:0] st;
        bit er, eerr, dk, tmo, wr, glitch;
        int low, s, r;
        for (int i = 0; i < 200; i++) begin
            s  = $urandom_range(0, 2);
            r  = $urandom_range(0, 9);
            a  = 9'($urandom_range(0, 63) * 4);
            if (r == 0) a = a | 9'($urandom_range(1, 3));
            if (r == 1 && s == 0) a = 9'(256 + $urandom_range(0, 255));
            wr     = 1'($urandom_range(0, 1));
            st     = (r == 2) ? 4'h0 : 4'($urandom);
            wd     = $urandom;
            glitch = ($urandom_range(0, 3) == 0);
            applyStimulus(s, wr, a, wd, st, glitch, rd, er, low, tmo);
            m_predict(s, wr, a, wd, st, erd, eerr, dk);
            compared++;
            if (tmo || low != ws_of(s) || er !== eerr || (dk && rd !== erd)) begin
                mismatched++;
                $display("[TB] FAIL random%0d dut%0d %s a=%h: got data=%h err=%b low=%0d, need data=%h err=%b low=%0d",
                         i, s, wr ? "wr" : "rd", a, rd, er, low, erd, eerr, ws_of(s));
            end
            if ($urandom_range(0, 4) == 0) begin
                @(posedge PCLK); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_basic();
        test_strobes();
        test_errors();
        test_wait_sweep();
        test_reset_mid();
        test_psel_drop();
        test_protect();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
